// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit boundary: branch redirect input, imem request/response channel, decode-side queue head.
`timescale 1ns/1ps
interface fetch_pc_unit_if;
  logic        RedirectValid;
  logic [31:0] RedirectPc;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemReqAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] InstData;
  logic [31:0] InstPc;
  logic [31:0] FetchPc;

  // Fetch unit side.
  modport master (
    input  RedirectValid, RedirectPc, ImemReqReady, ImemRespValid, ImemRespData, InstReady,
    output ImemReqValid, ImemReqAddr, InstValid, InstData, InstPc, FetchPc
  );

  // Environment side: branch unit, instruction memory and decode.
  modport slave (
    output RedirectValid, RedirectPc, ImemReqReady, ImemRespValid, ImemRespData, InstReady,
    input  ImemReqValid, ImemReqAddr, InstValid, InstData, InstPc, FetchPc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Architectural PC owner: issues in-order imem fetches, tags responses with their PC,
// queues them toward decode and discards stale responses after a redirect.
`timescale 1ns/1ps
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned IQ_DEPTH        = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_unit_if.master bus
);
  localparam int unsigned CW  = $clog2(IQ_DEPTH + 1);
  localparam int unsigned SW  = CW + 2;
  localparam int unsigned QAW = $clog2(IQ_DEPTH);
  localparam int unsigned TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {START, RUN, FLUSH} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   live_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occ;
  logic [31:0]     q_data [IQ_DEPTH];
  logic [31:0]     q_pc   [IQ_DEPTH];
  logic [QAW-1:0]  q_rd;
  logic [QAW-1:0]  q_wr;
  logic [31:0]     tag_pc [MAX_OUTSTANDING];
  logic [TAW-1:0]  tag_rd;
  logic [TAW-1:0]  tag_wr;

  logic [SW-1:0]   inflight_c;
  logic [SW-1:0]   credit_c;
  logic            req_valid_c;
  logic            accept_c;
  logic            resp_ok_c;
  logic            resp_drop_c;
  logic            resp_live_c;
  logic            push_c;
  logic            pop_c;
  logic [CW-1:0]   live_next_c;
  logic [CW-1:0]   drop_next_c;
  logic [CW-1:0]   occ_next_c;
  logic [CW-1:0]   redirect_drop_c;

  function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TAW'(1);
  endfunction

  // Live requests each reserve a queue slot; stale ones still hold imem credit until they return.
  always_comb begin
    inflight_c      = SW'(live_cnt) + SW'(drop_cnt);
    credit_c        = inflight_c + SW'(occ);
    req_valid_c     = (state != START) && !bus.RedirectValid &&
                      (credit_c < SW'(IQ_DEPTH)) && (inflight_c < SW'(MAX_OUTSTANDING));
    accept_c        = req_valid_c && bus.ImemReqReady;
    resp_ok_c       = bus.ImemRespValid && (inflight_c != '0);
    resp_drop_c     = resp_ok_c && (drop_cnt != '0);
    resp_live_c     = resp_ok_c && (drop_cnt == '0);
    push_c          = resp_live_c && !bus.RedirectValid;
    pop_c           = (occ != '0) && bus.InstReady;
    live_next_c     = live_cnt + CW'(accept_c) - CW'(resp_live_c);
    drop_next_c     = drop_cnt - CW'(resp_drop_c);
    occ_next_c      = occ + CW'(push_c) - CW'(pop_c);
    redirect_drop_c = drop_cnt + live_cnt - CW'(resp_ok_c);
  end

  assign bus.ImemReqValid = req_valid_c;
  assign bus.ImemReqAddr  = fetch_pc;
  assign bus.FetchPc      = fetch_pc;
  assign bus.InstValid    = (occ != '0);
  assign bus.InstData     = q_data[q_rd];
  assign bus.InstPc       = q_pc[q_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= START;
      fetch_pc <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      occ      <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
        q_data[QAW'(i)] <= '0;
        q_pc[QAW'(i)]   <= '0;
      end
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_pc[TAW'(i)] <= '0;
      end
    end else if (bus.RedirectValid) begin
      // Every request still in flight becomes stale; the queue restarts at the new PC.
      fetch_pc <= bus.RedirectPc & ~32'h3;
      occ      <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      live_cnt <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      drop_cnt <= redirect_drop_c;
      state    <= (redirect_drop_c != '0) ? FLUSH : RUN;
    end else begin
      if (accept_c) begin
        fetch_pc       <= fetch_pc + 32'd4;
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr         <= tag_inc(tag_wr);
      end
      if (resp_live_c) begin
        tag_rd <= tag_inc(tag_rd);
      end
      if (push_c) begin
        q_data[q_wr] <= bus.ImemRespData;
        q_pc[q_wr]   <= tag_pc[tag_rd];
        q_wr         <= q_wr + QAW'(1);
      end
      if (pop_c) begin
        q_rd <= q_rd + QAW'(1);
      end
      live_cnt <= live_next_c;
      drop_cnt <= drop_next_c;
      occ      <= occ_next_c;
      case (state)
        START:   state <= RUN;
        FLUSH:   if (drop_next_c == '0) state <= RUN;
        default: state <= state;
      endcase
    end
  end

  // A response with nothing in flight breaks the imem protocol; it is ignored above.
  ap_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.ImemRespValid |-> (inflight_c != '0));

endmodule
